// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer (parallel word -> serial bit stream).
package bit_serializer_pkg;

    // Shift FSM states; PARITY is only entered when BIT_SERIALIZER_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    localparam int SER_WIDTH_DEF = 8;

endpackage

// File: rtl/bit_serializer_if.sv
// Handshake and serial-stream bundle of the bit serializer.
// master: producer/consumer side; slave: the serializer itself.
interface bit_serializer_if #(
    parameter int WIDTH = bit_serializer_pkg::SER_WIDTH_DEF
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, out_bit, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, out_bit, out_valid, busy
    );
endinterface

// File: rtl/bit_serializer_hold_reg.sv
// ser_hold_reg: single-entry holding buffer between the word handshake and the shift FSM.
// Write and drain never coincide because the writer is only ready while the entry is empty.
module ser_hold_reg
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state: a write fills the entry, a drain empties it.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wr_en_i) begin
            full_d = 1'b1;
            data_d = wr_data_i;
        end else if (rd_en_i) begin
            full_d = 1'b0;
        end
    end

    // Occupancy flag is reset; the payload is only ever read while full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
        data_q <= data_d;
    end

    assign full_o = full_q;
    assign data_o = data_q;
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: accepts parallel words over valid/ready and emits one bit per cycle
// with a valid qualifier; a held word reloads on the last bit for zero-gap streaming.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN appends an even-parity bit per word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    bit_serializer_if.slave bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             accept;
    logic             drain;
    logic             word_end;

    // Bit presented first from a word, honouring the shift direction.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Remaining bits after the presented one has been removed.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign accept = bus.in_valid && !hold_full;

    ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (accept),
        .wr_data_i (bus.in_data),
        .rd_en_i   (drain),
        .full_o    (hold_full),
        .data_o    (hold_data)
    );

    // Next-state and output logic: load from the holding register, shift, or finish the word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d       = par_q;
`endif
        drain       = 1'b0;
        word_end    = 1'b0;

        case (state_q)
            IDLE: begin
                drain = hold_full;
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    out_bit_d = first_bit(shreg_q);
                    shreg_d   = shift_out(shreg_q);
                    cnt_d     = cnt_q + CNT_W'(1);
                end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d   = PARITY;
                    out_bit_d = par_q;
`else
                    word_end  = 1'b1;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                word_end = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // End of word: stream straight into the held word, or fall idle.
        if (word_end) begin
            if (hold_full) begin
                drain = 1'b1;
            end else begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_bit_d   = 1'b0;
            end
        end

        // Load: the first bit of the held word is presented on the same edge.
        if (drain) begin
            state_d     = SHIFT;
            cnt_d       = '0;
            out_bit_d   = first_bit(hold_data);
            shreg_d     = shift_out(hold_data);
            out_valid_d = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_d       = ^hold_data;
`endif
        end
    end

    // State, counter, shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign bus.in_ready  = !hold_full;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != IDLE) || hold_full;
endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: an MSB-first and an LSB-first instance,
// expected bit streams queued at acceptance and popped as valid bits appear.
module tb_bit_serializer;
    localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int WL = W + 1;
`else
    localparam int WL = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) bm ();
    bit_serializer_if #(.WIDTH(W)) bl ();

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bm));
    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bl));

    int   checks   = 0;
    int   failures = 0;
    logic exp_m[$];
    logic exp_l[$];
    int   vcnt_m   = 0;
    int   falls_m  = 0;
    int   vcnt_l   = 0;
    logic prev_m   = 1'b0;
    logic e_m, e_l;

    // Scoreboard: every valid bit is compared with the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (bm.out_valid) begin
                vcnt_m++;
                if (exp_m.size() == 0) begin
                    failures++;
                    $display("FAIL msb_extra_bit: valid bit %0b emitted, required no valid bit", bm.out_bit);
                end else begin
                    e_m = exp_m.pop_front();
                    if (bm.out_bit !== e_m) begin
                        failures++;
                        $display("FAIL msb_stream_bit: got %0b required %0b", bm.out_bit, e_m);
                    end
                end
            end else if (bm.out_bit !== 1'b0) begin
                failures++;
                $display("FAIL msb_idle_bit: got %0b required 0", bm.out_bit);
            end
            if (prev_m && !bm.out_valid) falls_m++;
            prev_m = bm.out_valid;

            checks++;
            if (bl.out_valid) begin
                vcnt_l++;
                if (exp_l.size() == 0) begin
                    failures++;
                    $display("FAIL lsb_extra_bit: valid bit %0b emitted, required no valid bit", bl.out_bit);
                end else begin
                    e_l = exp_l.pop_front();
                    if (bl.out_bit !== e_l) begin
                        failures++;
                        $display("FAIL lsb_stream_bit: got %0b required %0b", bl.out_bit, e_l);
                    end
                end
            end else if (bl.out_bit !== 1'b0) begin
                failures++;
                $display("FAIL lsb_idle_bit: got %0b required 0", bl.out_bit);
            end
        end
    end

    // Offer a word to the MSB-first instance; expected bits queued when it is accepted.
    task automatic send_m(input logic [W-1:0] d);
        bit done;
        done = 1'b0;
        bm.in_data  = d;
        bm.in_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (bm.in_ready === 1'b1) begin
                done = 1'b1;
                for (int b = W - 1; b >= 0; b--) exp_m.push_back(d[b]);
`ifdef BIT_SERIALIZER_PARITY_EN
                exp_m.push_back(^d);
`endif
            end
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL send_m_timeout: word %h accepted=0 required 1", d);
        end
    endtask

    // Offer a word to the LSB-first instance.
    task automatic send_l(input logic [W-1:0] d);
        bit done;
        done = 1'b0;
        bl.in_data  = d;
        bl.in_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (bl.in_ready === 1'b1) begin
                done = 1'b1;
                for (int b = 0; b < W; b++) exp_l.push_back(d[b]);
`ifdef BIT_SERIALIZER_PARITY_EN
                exp_l.push_back(^d);
`endif
            end
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL send_l_timeout: word %h accepted=0 required 1", d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bm.in_valid = 1'b0; bm.in_data = '0;
        bl.in_valid = 1'b0; bl.in_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bm.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b required 0", bm.out_valid); end
        checks++;
        if (bm.out_bit !== 1'b0) begin failures++; $display("FAIL reset_out_bit: got %0b required 0", bm.out_bit); end
        checks++;
        if (bm.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b required 1", bm.in_ready); end
        checks++;
        if (bm.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", bm.busy); end
        checks++;
        if (bl.in_ready !== 1'b1 || bl.busy !== 1'b0) begin
            failures++; $display("FAIL reset_lsb: ready=%0b busy=%0b required 1/0", bl.in_ready, bl.busy);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int nvalid;
        int det;
        logic [3:0] sh;
        nvalid = 0; det = 0; sh = '0;
        send_m(8'hD0);
        bm.in_valid = 1'b0;
        checks++;
        if (bm.out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %0b required 0", bm.out_valid); end
        checks++;
        if (bm.in_ready !== 1'b0 || bm.busy !== 1'b1) begin
            failures++; $display("FAIL single_held: ready=%0b busy=%0b required 0/1", bm.in_ready, bm.busy);
        end
        @(negedge clk);
        checks++;
        if (bm.out_valid !== 1'b1) begin failures++; $display("FAIL single_latency: out_valid=%0b required 1", bm.out_valid); end
        checks++;
        if (bm.in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_after_load: got %0b required 1", bm.in_ready); end
        for (int i = 0; i < WL + 4; i++) begin
            if (bm.out_valid === 1'b1) begin
                nvalid++;
                sh = {sh[2:0], bm.out_bit};
                if (sh == 4'b1101) det++;
            end
            @(negedge clk);
        end
        checks++;
        if (nvalid != WL) begin failures++; $display("FAIL single_length: got %0d required %0d", nvalid, WL); end
        checks++;
        if (det != 1) begin failures++; $display("FAIL single_detector: got %0d required 1", det); end
        checks++;
        if (exp_m.size() != 0) begin failures++; $display("FAIL single_drain: left %0d required 0", exp_m.size()); end
        checks++;
        if (bm.busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %0b required 0", bm.busy); end
    endtask

    task automatic test_back_to_back();
        int v0;
        int f0;
        v0 = vcnt_m; f0 = falls_m;
        send_m(8'hA5);
        checks++;
        if (bm.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_first: got %0b required 0", bm.in_ready); end
        send_m(8'h3C);
        bm.in_valid = 1'b0;
        checks++;
        if (bm.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_held: got %0b required 0", bm.in_ready); end
        repeat (3 * WL) @(negedge clk);
        checks++;
        if (vcnt_m - v0 != 2 * WL) begin failures++; $display("FAIL b2b_length: got %0d required %0d", vcnt_m - v0, 2 * WL); end
        checks++;
        if (falls_m - f0 != 1) begin failures++; $display("FAIL b2b_gap: valid drops=%0d required 1", falls_m - f0); end
        checks++;
        if (exp_m.size() != 0) begin failures++; $display("FAIL b2b_drain: left %0d required 0", exp_m.size()); end
    endtask

    task automatic test_lsb_first();
        int v0;
        v0 = vcnt_l;
        send_l(8'h01);
        bl.in_valid = 1'b0;
        repeat (2 * WL) @(negedge clk);
        checks++;
        if (vcnt_l - v0 != WL) begin failures++; $display("FAIL lsb_length: got %0d required %0d", vcnt_l - v0, WL); end
        checks++;
        if (exp_l.size() != 0) begin failures++; $display("FAIL lsb_drain: left %0d required 0", exp_l.size()); end
    endtask

`ifdef BIT_SERIALIZER_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] words [2];
        logic         want  [2];
        int           n;
        logic         last;
        words[0] = 8'h07; want[0] = 1'b1;
        words[1] = 8'h03; want[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0; last = 1'b0;
            send_m(words[k]);
            bm.in_valid = 1'b0;
            for (int i = 0; i < WL + 4; i++) begin
                if (bm.out_valid === 1'b1) begin
                    n++;
                    last = bm.out_bit;
                end
                @(negedge clk);
            end
            checks++;
            if (n != W + 1) begin failures++; $display("FAIL parity_length %h: got %0d required %0d", words[k], n, W + 1); end
            checks++;
            if (last !== want[k]) begin failures++; $display("FAIL parity_bit %h: got %0b required %0b", words[k], last, want[k]); end
        end
    endtask
`endif

    task automatic test_reset_mid();
        int v0;
        send_m(8'hFF);
        send_m(8'h55);
        bm.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bm.out_valid !== 1'b1 || bm.in_ready !== 1'b0) begin
            failures++; $display("FAIL midrst_pre: valid=%0b ready=%0b required 1/0", bm.out_valid, bm.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bm.out_valid !== 1'b0 || bm.out_bit !== 1'b0) begin
            failures++; $display("FAIL midrst_out: valid=%0b bit=%0b required 0/0", bm.out_valid, bm.out_bit);
        end
        checks++;
        if (bm.in_ready !== 1'b1 || bm.busy !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl: ready=%0b busy=%0b required 1/0", bm.in_ready, bm.busy);
        end
        exp_m.delete();
        rst = 1'b1;
        v0 = vcnt_m;
        repeat (3 * WL) @(negedge clk);
        checks++;
        if (vcnt_m - v0 != 0) begin failures++; $display("FAIL midrst_discard: valid bits=%0d required 0", vcnt_m - v0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
`ifdef BIT_SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream stage of the serial sequence detector: accepts parallel words over a valid/ready handshake and emits them as a continuous one-bit-per-cycle stream with a bit-valid qualifier. The serial output drives the detector's `in` directly. A single-entry holding register lets consecutive words stream with no idle cycle between them.

## Interface
- `WIDTH`, default 8: data bits per word, legal range 2–32.
- `MSB_FIRST`, default 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset, synchronous, active-low.
- `in_data`, input, `WIDTH`: parallel word.
- `in_valid`, input, 1: `in_data` valid.
- `in_ready`, output, 1: holding register empty; equals `~hold_full`, combinational from a register.
- `out_bit`, output, 1: serial bit, registered; 0 whenever `out_valid`=0.
- `out_valid`, output, 1: `out_bit` is a data or parity bit, registered.
- `busy`, output, 1: shift FSM not IDLE, or holding register full.

## Operation
- Accept: a word is accepted at an edge where `in_valid` && `in_ready` are both 1; it is written to the holding register and `hold_full` is set.
- Producers must hold `in_data` stable while `in_valid`=1 and `in_ready`=0. No data is lost.
- FSM states:
  - IDLE.
  - SHIFT: bit counter runs 0..`WIDTH-1`.
  - PARITY: present only with the macro.
- Transfers:
  - IDLE with `hold_full`: load the shift register, clear `hold_full`, go to SHIFT, present the first bit.
  - SHIFT with counter < `WIDTH-1`: shift one bit, increment the counter.
  - SHIFT at the last bit, then the word end (PARITY if enabled, otherwise the last data bit):
    - `hold_full`: reload from the holding register, counter=0, stay in SHIFT (zero-gap streaming).
    - Not `hold_full`: go to IDLE, `out_valid`=0, `out_bit`=0.
- No bypass: a hold→shift transfer and a new accept never occur on the same edge, because `in_ready` is 0 while `hold_full`=1.
- Counter width is `$clog2(WIDTH)`. The counter never wraps past `WIDTH-1`; it resets to 0 on every load.
- Reset values (`rst`=0 at an edge): FSM=IDLE, `hold_full`=0, counter=0, shift register=0, `out_bit`=0, `out_valid`=0.
  - After reset, `in_ready`=1 and `busy`=0.
  - A reset mid-word discards the partially shifted word and the held word, with no partial completion.
- If `rst`=0 and `in_valid`=1 on the same edge, reset wins and nothing is accepted.

## Timing
- Accept at edge N; load at edge N+1; first bit is valid in the cycle after edge N+1.
  - Latency is 2 edges from accept to first `out_valid`.
- The word occupies `WIDTH` consecutive valid cycles, or `WIDTH+1` with parity.
- Sustained throughput is 1 word per `WIDTH` (or `WIDTH+1`) cycles, with `out_valid` never dropping when the producer keeps the holding register filled.
- `in_ready` rises at the edge where the holding register drains into the shift register.

## Configuration
- `BIT_SERIALIZER_PARITY_EN`:
  - Defined: after the last data bit, one extra valid cycle carries even parity, the XOR of all `WIDTH` data bits. The PARITY state exists.
  - Undefined: no PARITY state; words are exactly `WIDTH` bits.

## Structure
- Package `bit_serializer_pkg`:
  - state enum typedef (IDLE, SHIFT, PARITY);
  - default width constant `SER_WIDTH_DEF`=8.
- One sub-module, `ser_hold_reg`: the single-entry valid/ready holding buffer (`hold_full`, data, load/drain controls).
- Shift FSM and output registers live in the top.

## Test plan
- Reset with `rst`=0 for 2 cycles → `out_valid`=0, `out_bit`=0, `in_ready`=1, `busy`=0.
- Single word 8'hD0, `MSB_FIRST`=1 → first valid 2 edges after accept; `out_bit` sequence 1,1,0,1,0,0,0,0; a downstream 1101 detector fires exactly once.
- Back-to-back 8'hA5 then 8'h3C, `in_valid` held → 16 contiguous valid cycles, 1010_0101_0011_1100; `in_ready` low while held.
- `MSB_FIRST`=0, word 8'h01 → sequence 1,0,0,0,0,0,0,0.
- With `BIT_SERIALIZER_PARITY_EN`, word 8'h07 → 9 valid cycles, ninth bit = 1; word 8'h03 → ninth bit = 0.
- Reset asserted at bit 4 of 8'hFF with 8'h55 held → next edge `out_valid`=0, `in_ready`=1; 8'h55 is never emitted.
